// File: rtl/m_unit_seq_pkg.sv
// Shared constants for the iterative RV32M unit: FSM states, func3 M-op encodings and
// the special-case result helper used by both the early-out and the fix-up path.
package m_unit_seq_pkg;

  localparam int unsigned MXlen = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mop_e;

  function automatic logic is_div(logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_rem(logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // Divide-by-zero or signed-overflow result; only meaningful for divide ops.
  function automatic logic [MXlen-1:0] special_res(logic [2:0] f3, logic [MXlen-1:0] a,
                                                   logic dz);
    logic [MXlen-1:0] r;
    if (dz) r = is_rem(f3) ? a : '1;
    else    r = is_rem(f3) ? '0 : {1'b1, {(MXlen-1){1'b0}}};
    return r;
  endfunction

endpackage

// File: rtl/m_unit_operand_prep.sv
// Combinational operand preparation: magnitudes of both operands and the sign of the
// final product/quotient and remainder, according to the signedness of the M-op.
module m_unit_operand_prep
  import m_unit_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] abs_a_o,
  output logic [XLEN-1:0] abs_b_o,
  output logic            neg_res_o,
  output logic            neg_rem_o
);

  logic signed_a, signed_b, neg_a, neg_b;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (func3_i)
      OpMulh, OpDiv, OpRem: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      OpMulhsu: signed_a = 1'b1;
      default: ;
    endcase
    neg_a     = signed_a & op_a_i[XLEN-1];
    neg_b     = signed_b & op_b_i[XLEN-1];
    // The most negative value negates to itself and is then read as an unsigned magnitude.
    abs_a_o   = neg_a ? -op_a_i : op_a_i;
    abs_b_o   = neg_b ? -op_b_i : op_b_i;
    neg_res_o = neg_a ^ neg_b;
    neg_rem_o = neg_a;
  end

endmodule

// File: rtl/m_unit_seq.sv
// Iterative RV32M execute unit: one shared 64-bit shift datapath, one result bit per cycle.
// Optional M_UNIT_EARLY_OUT_EN skips the iterations for trivially known results.
module m_unit_seq
  import m_unit_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic [XLEN-1:0]   abs_a, abs_b;
  logic              neg_res, neg_rem;
  logic              dz_now, ovf_now;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem, quo, rem;

  m_unit_operand_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .func3_i   (func3),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .abs_a_o   (abs_a),
    .abs_b_o   (abs_b),
    .neg_res_o (neg_res),
    .neg_rem_o (neg_rem)
  );

  // acc holds {product hi, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    dz_now   = (op_b == '0);
    ovf_now  = ((func3 == OpDiv) || (func3 == OpRem)) && (op_a == MinNeg) && (op_b == '1);
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_ge   = (acc_q[2*XLEN-1:XLEN-1] >= {1'b0, b_q});
    div_rem  = acc_q[2*XLEN-2:XLEN-1] - b_q;
    div_next = div_ge ? {div_rem, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
    prod     = neg_res_q ? -acc_q : acc_q;
    quo      = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func3_d   = func3_q;
    rd_d      = rd_q;
    op_a_d    = op_a_q;
    b_d       = b_q;
    res_d     = res_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    busy_d    = (state_q != StIdle);
    done_d    = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          func3_d   = func3;
          rd_d      = rd_in;
          op_a_d    = op_a;
          b_d       = abs_b;
          acc_d     = {{XLEN{1'b0}}, abs_a};
          neg_res_d = neg_res;
          neg_rem_d = neg_rem;
          dz_d      = dz_now;
          ovf_d     = ovf_now;
          cnt_d     = '0;
          state_d   = StCalc;
`ifdef M_UNIT_EARLY_OUT_EN
          if (is_div(func3) ? (dz_now || ovf_now) : ((op_a == '0) || (op_b == '0))) begin
            res_d   = is_div(func3) ? special_res(func3, op_a, dz_now) : '0;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        acc_d = is_div(func3_q) ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end
      StFix: begin
        unique case (func3_q)
          OpMul:                     res_d = prod[XLEN-1:0];
          OpMulh, OpMulhsu, OpMulhu: res_d = prod[2*XLEN-1:XLEN];
          OpDiv, OpDivu:             res_d = quo;
          OpRem, OpRemu:             res_d = rem;
          default:                   res_d = '0;
        endcase
        if (is_div(func3_q) && (dz_q || ovf_q)) res_d = special_res(func3_q, op_a_q, dz_q);
        state_d = StDone;
      end
      StDone: begin
        done_d   = 1'b1;
        result_d = res_q;
        rd_out_d = rd_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Kill wins over everything, including a start presented in the same cycle.
    if (flush) begin
      state_d  = StIdle;
      cnt_d    = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      op_a_q    <= '0;
      b_q       <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func3_q   <= func3_d;
      rd_q      <= rd_d;
      op_a_q    <= op_a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_m_unit_seq.sv
// Self-checking bench for m_unit_seq; expected results queued at issue and checked at done.
module tb_m_unit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_res = 32'h0;

  m_unit_seq #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = $signed({32'h0, a});
    ub = $signed({32'h0, b});
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    int l;
    l = 34;
`ifdef M_UNIT_EARLY_OUT_EN
    if (f[2]) begin
      if (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
        l = 1;
    end else if (a == 0 || b == 0) begin
      l = 1;
    end
`endif
    return l;
  endfunction

  // Called #1 after an edge; the start is accepted at the next edge.
  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [31:0] exp_res,
                             input bit push, input string name);
    exp_t e;
    func3 = f;
    op_a  = a;
    op_b  = b;
    rd_in = rd;
    start = 1'b1;
    if (push) begin
      e.res  = exp_res;
      e.rd   = rd;
      e.lat  = exp_lat(f, a, b);
      e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    exp_t e;
    int   cyc;
    bit   got, busy_ok;
    cyc = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard: queue empty, got 0 entries want 1");
      return;
    end
    n_pass++;
    e = sb_q.pop_front();
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      $display("FAIL %s timeout: done seen %0d want 1", e.name, got);
    end else begin
      n_pass++;
      n_checks++;
      if (cyc !== e.lat) $display("FAIL %s latency: got %0d want %0d", e.name, cyc, e.lat);
      else n_pass++;
      n_checks++;
      if (busy_ok !== 1'b1) $display("FAIL %s busy: got low want high until done", e.name);
      else n_pass++;
      n_checks++;
      if (result !== e.res) $display("FAIL %s result: got %h want %h", e.name, result, e.res);
      else n_pass++;
      n_checks++;
      if (rd_out !== e.rd) $display("FAIL %s rd_out: got %0d want %0d", e.name, rd_out, e.rd);
      else n_pass++;
      last_res = e.res;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    func3 = 3'd0;
    op_a = 32'h0;
    op_b = 32'h0;
    rd_in = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else n_pass++;
    n_checks++;
    if (result !== 32'h0) $display("FAIL reset result: got %h want 0", result); else n_pass++;
    n_checks++;
    if (rd_out !== 5'd0) $display("FAIL reset rd_out: got %0d want 0", rd_out); else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    drive_start(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, "mul");
    n_checks++;
    if (busy !== 1'b0) $display("FAIL mul busy_c0: got %b want 0", busy); else n_pass++;
    wait_done();
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL mul done_pulse: got %b want 0", done); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL mul busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mulh();
    drive_start(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b1, "mulh");
    wait_done();
    drive_start(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b1, "mulhu");
    wait_done();
    drive_start(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b1, "mulhsu");
    wait_done();
  endtask

  task automatic test_div();
    drive_start(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1'b1, "div");
    wait_done();
    drive_start(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b1, "rem");
    wait_done();
    drive_start(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 1'b1, "divu");
    wait_done();
    drive_start(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 1'b1, "remu");
    wait_done();
  endtask

  task automatic test_div_special();
    drive_start(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b1, "divu_by0");
    wait_done();
    drive_start(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1'b1, "rem_by0");
    wait_done();
    drive_start(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1, "div_ovf");
    wait_done();
    drive_start(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1'b1, "rem_ovf");
    wait_done();
  endtask

  task automatic test_flush();
    drive_start(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd13, 32'h0, 1'b0, "div_flushed");
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL flush busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL flush done: got %b want 0", done); else n_pass++;
    n_checks++;
    if (result !== last_res) $display("FAIL flush result: got %h want %h", result, last_res);
    else n_pass++;
    drive_start(3'd5, 32'd1000, 32'd9, 5'd14, 32'd111, 1'b1, "divu_after_flush");
    wait_done();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a, b;
    drive_start(3'd0, 32'd0, 32'd12345, 5'd15, 32'd0, 1'b1, "mul_zero");
    for (int i = 0; i < 8; i++) begin
      wait_done();
      f = 3'(i);
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      drive_start(f, a, b, 5'(16 + i), model(f, a, b), 1'b1, "b2b");
    end
    wait_done();
  endtask

  task automatic test_async_reset();
    drive_start(3'd0, 32'd3, 32'd9, 5'd20, 32'h0, 1'b0, "mul_reset");
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    start = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL areset busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL areset done: got %b want 0", done); else n_pass++;
    n_checks++;
    if (result !== 32'h0) $display("FAIL areset result: got %h want 0", result); else n_pass++;
    n_checks++;
    if (rd_out !== 5'd0) $display("FAIL areset rd_out: got %0d want 0", rd_out); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL areset held_start: got busy %b want 0", busy);
    else n_pass++;
    #2;
    rst = 1'b0;
    start = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) break;
    end
    n_checks++;
    if (done !== 1'b0) $display("FAIL areset no_done: got %b want 0", done); else n_pass++;
    last_res = 32'h0;
    drive_start(3'd0, 32'd6, 32'd7, 5'd21, 32'd42, 1'b1, "mul_after_reset");
    wait_done();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_special();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
